// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller and its neighbours.
//   - FSM state encoding (also exported on the debug port)
//   - config-bus register addresses
//   - opcode constants shared with jump control
//   - lowest_set(): fixed-priority pick, bit 0 highest
package irq_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_HOLD1   = 3'd2,
    ST_HOLD2   = 3'd3,
    ST_SERVICE = 3'd4
  } irq_state_e;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd3;

  localparam logic [5:0] RET_OP    = 6'b010000;
  localparam logic [5:0] JMP_OP    = 6'b011000;
  localparam logic [2:0] JMP_CLASS = 3'b011;

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_controller_sync_edge.sv
// One request line: 2-flop synchronizer followed by a delayed copy that
// turns the synchronized level into a single-cycle rising-edge pulse.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   d_i     raw asynchronous request level
//   rise_o  one-cycle pulse, high the cycle after the level reaches sync2
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~dly_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes and edge-detects request lines, keeps
// MASK/PENDING/CTRL registers on a 2-bit config bus, picks the lowest
// eligible request and issues a one-cycle interrupt pulse to jump control,
// then stays in service until the ISR's RET opcode is seen.
// Ports:
//   clk, reset (async, active-low)
//   irq_in      raw request lines
//   op          opcode currently in the jump-control stage
//   jc_busy     jump control redirect in progress
//   cfg_we/cfg_addr/cfg_wdata/cfg_rdata  register bus (read is combinational)
//   interrupt   one-cycle pulse to jump control
//   irq_active  high from the pulse until RET completes
//   irq_id      index of the in-service request
//   dbg_state   current FSM state
//
// Handshake: there is no ready/valid back-pressure on the interrupt pulse;
// the controller only fires when jc_busy is low and the current opcode is
// not a jump or RET, which is jump control's condition for accepting it.
module irq_controller #(
  parameter int         NUM_IRQ = 4,
  parameter logic [5:0] RET_OP  = irq_controller_pkg::RET_OP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [5:0]         op,
  input  logic               jc_busy,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               interrupt,
  output logic               irq_active,
  output logic [2:0]         irq_id,
  output logic [2:0]         dbg_state
);
  import irq_controller_pkg::*;

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic               gie_q, gie_d;
  logic [2:0]         id_q, id_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [7:0]         elig_ext;
  logic [2:0]         winner;
  logic               issue;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (irq_in[g]),
      .rise_o (rise[g])
    );
  end

  assign eligible = pend_q & mask_q;

  always_comb begin
    elig_ext = '0;
    elig_ext[NUM_IRQ-1:0] = eligible;
  end

  assign winner = lowest_set(elig_ext);

  // Arbitration only in IDLE; a jump or RET in flight would collide with
  // the redirect the interrupt itself causes.
  assign issue = (state_q == ST_IDLE) && gie_q && (|eligible) && !jc_busy &&
                 (op[5:3] != JMP_CLASS) && (op != RET_OP);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_ISSUE;
          id_d    = winner;
        end
      end
      ST_ISSUE:   state_d = ST_HOLD1;
      ST_HOLD1:   state_d = ST_HOLD2;
      ST_HOLD2:   state_d = ST_SERVICE;
      ST_SERVICE: if (op == RET_OP) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Register writes; a new edge is OR-ed in last so it beats both the
  // write-1-to-clear and the issue clear of the same bit.
  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    pend_d = pend_q;
    if (cfg_we) begin
      case (cfg_addr)
        ADDR_MASK: mask_d = cfg_wdata[NUM_IRQ-1:0];
        ADDR_PEND: pend_d = pend_q & ~cfg_wdata[NUM_IRQ-1:0];
        ADDR_CTRL: gie_d  = cfg_wdata[0];
        default:   ;
      endcase
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (issue && (winner == 3'(i))) pend_d[i] = 1'b0;
    end
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      gie_q   <= 1'b0;
      id_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      gie_q   <= gie_d;
      id_q    <= id_d;
    end
  end

  assign interrupt  = (state_q == ST_ISSUE);
  assign irq_active = (state_q != ST_IDLE);
  assign irq_id     = id_q;
  assign dbg_state  = state_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[NUM_IRQ-1:0] = mask_q;
      ADDR_PEND: cfg_rdata[NUM_IRQ-1:0] = pend_q;
      ADDR_CTRL: cfg_rdata[0] = gie_q;
      default:   cfg_rdata = {irq_active, 12'b0, id_q};
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  import irq_controller_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic [5:0]  op;
  logic        jc_busy;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        interrupt;
  logic        irq_active;
  logic [2:0]  irq_id;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] rd_val;

  irq_controller #(.NUM_IRQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .op         (op),
    .jc_busy    (jc_busy),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .interrupt  (interrupt),
    .irq_active (irq_active),
    .irq_id     (irq_id),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  // called right after ISSUE has been observed: walk to SERVICE, RET out
  task automatic finish_service();
    tick(3);
    op = RET_OP;
    tick(1);
    op = 6'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_in = '0; op = '0; jc_busy = 0;
    cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    tick(2);
    checks++; if (interrupt !== 1'b0 || irq_active !== 1'b0 || irq_id !== 3'd0) begin
      errors++; $display("FAIL rst_out: got int=%b act=%b id=%0d want 0/0/0", interrupt, irq_active, irq_id); end
    rd(ADDR_MASK, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL rst_mask: got %h want 0000", rd_val); end
    rd(ADDR_CTRL, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0000", rd_val); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    cfg_write(ADDR_MASK, 16'h0002);
    cfg_write(ADDR_CTRL, 16'h0001);
    irq_in = 4'b0010;
    tick(2); // edges k, k+1
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL t1_pend_early: got %h want 0000", rd_val); end
    tick(1); // k+2
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0002) begin errors++; $display("FAIL t1_pend_set: got %h want 0002", rd_val); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t1_int_early: got %b want 0", interrupt); end
    tick(1); // k+3: ISSUE
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd1 || irq_active !== 1'b1) begin
      errors++; $display("FAIL t1_issue: got int=%b id=%0d act=%b want 1/1/1", interrupt, irq_id, irq_active); end
    rd(ADDR_ID, rd_val);
    checks++; if (rd_val !== 16'h8001) begin errors++; $display("FAIL t1_id_reg: got %h want 8001", rd_val); end
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL t1_pend_clr: got %h want 0000", rd_val); end
    tick(1);
    checks++; if (interrupt !== 1'b0 || irq_active !== 1'b1) begin
      errors++; $display("FAIL t1_pulse_len: got int=%b act=%b want 0/1", interrupt, irq_active); end
    tick(2);
    checks++; if (dbg_state !== 3'(ST_SERVICE)) begin errors++; $display("FAIL t1_service: got %0d want 4", dbg_state); end
    op = 6'b010000;
    tick(1);
    checks++; if (irq_active !== 1'b0 || irq_id !== 3'd1) begin
      errors++; $display("FAIL t1_ret: got act=%b id=%0d want 0/1", irq_active, irq_id); end
    op = 6'd0; irq_in = '0;
    tick(3);
  endtask

  task automatic test_priority();
    cfg_write(ADDR_MASK, 16'h000F);
    irq_in = 4'b1001;
    tick(4);
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd0) begin
      errors++; $display("FAIL t2_first: got int=%b id=%0d want 1/0", interrupt, irq_id); end
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0008) begin errors++; $display("FAIL t2_pend: got %h want 0008", rd_val); end
    finish_service();
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL t2_ret: got %b want 0", irq_active); end
    tick(1);
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd3) begin
      errors++; $display("FAIL t2_second: got int=%b id=%0d want 1/3", interrupt, irq_id); end
    finish_service();
    irq_in = '0;
    tick(3);
  endtask

  task automatic test_busy_and_jump();
    jc_busy = 1'b1;
    irq_in = 4'b0100;
    tick(3); // pending set at k+2
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0004) begin errors++; $display("FAIL t3_pend: got %h want 0004", rd_val); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (interrupt !== 1'b0 || irq_active !== 1'b0) begin
        errors++; $display("FAIL t3_busy%0d: got int=%b act=%b want 0/0", i, interrupt, irq_active); end
    end
    jc_busy = 1'b0;
    tick(1);
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd2) begin
      errors++; $display("FAIL t3_after_busy: got int=%b id=%0d want 1/2", interrupt, irq_id); end
    finish_service();
    irq_in = '0;
    tick(3);
    op = 6'b011110; // JZ
    irq_in = 4'b0010;
    tick(6);
    checks++; if (interrupt !== 1'b0 || irq_active !== 1'b0) begin
      errors++; $display("FAIL t3_jz_block: got int=%b act=%b want 0/0", interrupt, irq_active); end
    op = 6'd0;
    tick(1);
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd1) begin
      errors++; $display("FAIL t3_after_jz: got int=%b id=%0d want 1/1", interrupt, irq_id); end
    finish_service();
    irq_in = '0;
    tick(3);
  endtask

  task automatic test_gie_w1c();
    cfg_write(ADDR_CTRL, 16'h0000);
    irq_in = 4'b0100;
    tick(3);
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0004) begin errors++; $display("FAIL t4_pend: got %h want 0004", rd_val); end
    tick(1);
    checks++; if (interrupt !== 1'b0 || irq_active !== 1'b0) begin
      errors++; $display("FAIL t4_gie_off: got int=%b act=%b want 0/0", interrupt, irq_active); end
    cfg_write(ADDR_PEND, 16'h0004);
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL t4_w1c: got %h want 0000", rd_val); end
    cfg_write(ADDR_CTRL, 16'h0001);
    tick(2);
    checks++; if (interrupt !== 1'b0 || dbg_state !== 3'(ST_IDLE)) begin
      errors++; $display("FAIL t4_no_int: got int=%b st=%0d want 0/0", interrupt, dbg_state); end
    irq_in = '0;
    tick(3);
  endtask

  task automatic test_set_wins_and_hold_ret();
    cfg_write(ADDR_CTRL, 16'h0000);
    irq_in = 4'b0100;
    tick(2); // edges k, k+1
    cfg_we = 1'b1; cfg_addr = ADDR_PEND; cfg_wdata = 16'h0004;
    tick(1); // k+2: edge-set and W1C together
    cfg_we = 1'b0;
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0004) begin errors++; $display("FAIL t5_set_wins: got %h want 0004", rd_val); end
    cfg_write(ADDR_CTRL, 16'h0001);
    tick(1);
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd2) begin
      errors++; $display("FAIL t5_issue: got int=%b id=%0d want 1/2", interrupt, irq_id); end
    op = RET_OP;
    tick(1);
    checks++; if (dbg_state !== 3'(ST_HOLD1) || irq_active !== 1'b1) begin
      errors++; $display("FAIL t5_hold1: got st=%0d act=%b want 2/1", dbg_state, irq_active); end
    tick(1);
    op = 6'd0;
    tick(1);
    checks++; if (dbg_state !== 3'(ST_SERVICE) || irq_active !== 1'b1) begin
      errors++; $display("FAIL t5_service: got st=%0d act=%b want 4/1", dbg_state, irq_active); end
    op = RET_OP;
    tick(1);
    op = 6'd0;
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL t5_ret: got %b want 0", irq_active); end
    irq_in = '0;
    tick(3);
  endtask

  task automatic test_reset_mid_service();
    irq_in = 4'b1000;
    tick(4);
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd3) begin
      errors++; $display("FAIL t6_issue: got int=%b id=%0d want 1/3", interrupt, irq_id); end
    tick(3);
    checks++; if (dbg_state !== 3'(ST_SERVICE)) begin errors++; $display("FAIL t6_service: got %0d want 4", dbg_state); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (irq_active !== 1'b0 || irq_id !== 3'd0 || interrupt !== 1'b0) begin
      errors++; $display("FAIL t6_async: got act=%b id=%0d int=%b want 0/0/0", irq_active, irq_id, interrupt); end
    rd(ADDR_MASK, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL t6_mask: got %h want 0000", rd_val); end
    rd(ADDR_CTRL, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL t6_ctrl: got %h want 0000", rd_val); end
    irq_in = '0;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (interrupt !== 1'b0 || irq_active !== 1'b0) begin
        errors++; $display("FAIL t6_post%0d: got int=%b act=%b want 0/0", i, interrupt, irq_active); end
    end
    rd(ADDR_PEND, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL t6_pend: got %h want 0000", rd_val); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_busy_and_jump();
    test_gie_w1c();
    test_set_wins_and_hold_ret();
    test_reset_mid_service();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
